// File: rtl/fifo_param_flow.sv
// Parametrised synchronous FIFO with programmable almost-full/empty thresholds,
// occupancy count, hysteretic pause output and registered pop data.
module fifo_param_flow #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] data_in_push,
    input  logic [ADDR_SIZE:0]   umbral_af,
    input  logic [ADDR_SIZE:0]   umbral_ae,
    output logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 valid_out,
    output logic [ADDR_SIZE:0]   fifo_count,
    output logic                 Fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_pause,
    output logic                 fifo_error
);
    localparam int                 DEPTH   = 2**ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] W_DEPTH = (ADDR_SIZE+1)'(DEPTH);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_valid, r_pause, r_error;

    logic                 w_rd_ok, w_wr_ok, w_ovf, w_unf;
    logic [ADDR_SIZE:0]   w_count_next;

    // A read frees a slot on the same edge, so a full FIFO still accepts a paired write.
    assign w_rd_ok      = read & (r_count != '0);
    assign w_wr_ok      = write & ((r_count != W_DEPTH) | w_rd_ok);
    assign w_ovf        = write & ~w_wr_ok;
    assign w_unf        = read & ~w_rd_ok;
    assign w_count_next = r_count + (ADDR_SIZE+1)'(w_wr_ok) - (ADDR_SIZE+1)'(w_rd_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_pause    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ADDR_SIZE'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + ADDR_SIZE'(1);
            r_count <= w_count_next;
            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_valid    <= 1'b1;
            end else begin
                r_valid    <= 1'b0;
            end
            // Set has priority so overlapping thresholds resolve to pause asserted.
            if (w_count_next >= umbral_af)      r_pause <= 1'b1;
            else if (w_count_next <= umbral_ae) r_pause <= 1'b0;
            if (w_ovf | w_unf) r_error <= 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !reset) r_mem[r_wr_ptr] <= data_in_push;
    end

    assign data_out_pop = r_data_out;
    assign valid_out    = r_valid;
    assign fifo_pause   = r_pause;
    assign fifo_error   = r_error;
    assign fifo_count   = r_count;
    assign Fifo_full    = (r_count == W_DEPTH);
    assign fifo_empty   = (r_count == '0);
    assign almost_full  = (r_count >= umbral_af);
    assign almost_empty = (r_count <= umbral_ae);
endmodule

// File: tb/tb_fifo_param_flow.sv
// Scoreboard bench: stimulus queues expected pop data, monitors check it on valid_out.
module tb_fifo_param_flow;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DUT A: default 4x8
    logic       rstA, wA, rA, vA, fullA, emptyA, afA, aeA, pauseA, errA;
    logic [7:0] dinA, doutA;
    logic [2:0] uafA, uaeA, cntA;
    fifo_param_flow #(.DATA_SIZE(8), .ADDR_SIZE(2)) u_a (
        .clk(clk), .reset(rstA), .write(wA), .read(rA), .data_in_push(dinA),
        .umbral_af(uafA), .umbral_ae(uaeA), .data_out_pop(doutA), .valid_out(vA),
        .fifo_count(cntA), .Fifo_full(fullA), .fifo_empty(emptyA), .almost_full(afA),
        .almost_empty(aeA), .fifo_pause(pauseA), .fifo_error(errA));

    // DUT B: 8x16
    logic        rstB, wB, rB, vB, fullB, emptyB, afB, aeB, pauseB, errB;
    logic [15:0] dinB, doutB;
    logic [3:0]  uafB, uaeB, cntB;
    fifo_param_flow #(.DATA_SIZE(16), .ADDR_SIZE(3)) u_b (
        .clk(clk), .reset(rstB), .write(wB), .read(rB), .data_in_push(dinB),
        .umbral_af(uafB), .umbral_ae(uaeB), .data_out_pop(doutB), .valid_out(vB),
        .fifo_count(cntB), .Fifo_full(fullB), .fifo_empty(emptyB), .almost_full(afB),
        .almost_empty(aeB), .fifo_pause(pauseB), .fifo_error(errB));

    logic [7:0]  mqA[$], expA[$];
    logic [15:0] mqB[$], expB[$];
    logic        errB_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: compare popped data against the scoreboard whenever valid_out is high.
    always @(negedge clk) begin
        if (vA === 1'b1) begin
            n_cmp++;
            if (expA.size() == 0) begin
                n_err++;
                $display("FAIL popA: got %0h expected no pop", doutA);
            end else begin
                logic [7:0] e;
                e = expA.pop_front();
                if (doutA !== e) begin
                    n_err++;
                    $display("FAIL popA: got %0h expected %0h", doutA, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (vB === 1'b1) begin
            n_cmp++;
            if (expB.size() == 0) begin
                n_err++;
                $display("FAIL popB: got %0h expected no pop", doutB);
            end else begin
                logic [15:0] e;
                e = expB.pop_front();
                if (doutB !== e) begin
                    n_err++;
                    $display("FAIL popB: got %0h expected %0h", doutB, e);
                end
            end
        end
    end

    // Called at a negedge; drives one cycle of stimulus and returns at the next negedge.
    task automatic opA(input logic w, input logic r, input logic [7:0] d);
        logic rok, wok;
        wA = w; rA = r; dinA = d;
        rok = r && (mqA.size() != 0);
        wok = w && ((mqA.size() != 4) || rok);
        if (rok) expA.push_back(mqA.pop_front());
        if (wok) mqA.push_back(d);
        @(negedge clk);
        wA = 1'b0; rA = 1'b0;
    endtask

    task automatic opB(input logic w, input logic r, input logic [15:0] d);
        logic rok, wok;
        wB = w; rB = r; dinB = d;
        rok = r && (mqB.size() != 0);
        wok = w && ((mqB.size() != 8) || rok);
        if ((w && !wok) || (r && !rok)) errB_m = 1'b1;
        if (rok) expB.push_back(mqB.pop_front());
        if (wok) mqB.push_back(d);
        @(negedge clk);
        wB = 1'b0; rB = 1'b0;
    endtask

    initial begin
        logic [7:0] pa [4];
        rstA = 1'b1; wA = 1'b0; rA = 1'b0; dinA = '0; uafA = 3'd3; uaeA = 3'd1;
        rstB = 1'b1; wB = 1'b0; rB = 1'b0; dinB = '0; uafB = 4'd6; uaeB = 4'd2;
        @(negedge clk); @(negedge clk);

        // 1. reset state
        chk("rst count", cntA, 0);   chk("rst empty", emptyA, 1); chk("rst full", fullA, 0);
        chk("rst af", afA, 0);       chk("rst ae", aeA, 1);       chk("rst pause", pauseA, 0);
        chk("rst error", errA, 0);   chk("rst valid", vA, 0);     chk("rst dout", doutA, 0);
        rstA = 1'b0; rstB = 1'b0;

        // 2. fill then drain with threshold and pause tracking
        pa[0] = 8'hA1; pa[1] = 8'hA2; pa[2] = 8'hA3; pa[3] = 8'hA4;
        opA(1, 0, pa[0]); chk("p1 count", cntA, 1); chk("p1 ae", aeA, 1); chk("p1 pause", pauseA, 0);
        opA(1, 0, pa[1]); chk("p2 count", cntA, 2); chk("p2 ae", aeA, 0); chk("p2 af", afA, 0);
        opA(1, 0, pa[2]); chk("p3 count", cntA, 3); chk("p3 af", afA, 1); chk("p3 pause", pauseA, 1);
        opA(1, 0, pa[3]); chk("p4 count", cntA, 4); chk("p4 full", fullA, 1); chk("p4 pause", pauseA, 1);
        opA(0, 1, 0); chk("r1 valid", vA, 1); chk("r1 count", cntA, 3); chk("r1 pause", pauseA, 1);
        opA(0, 1, 0); chk("r2 count", cntA, 2); chk("r2 pause hold", pauseA, 1);
        opA(0, 1, 0); chk("r3 count", cntA, 1); chk("r3 pause clr", pauseA, 0);
        opA(0, 1, 0); chk("r4 count", cntA, 0); chk("r4 empty", emptyA, 1); chk("r4 error", errA, 0);

        // 3. overflow, then paired read/write on a full FIFO
        opA(1, 0, 8'hB1); opA(1, 0, 8'hB2); opA(1, 0, 8'hB3); opA(1, 0, 8'hB4);
        opA(1, 0, 8'h55); chk("ovf error", errA, 1); chk("ovf count", cntA, 4);
        opA(1, 1, 8'h66); chk("rw full count", cntA, 4); chk("rw full valid", vA, 1);
        opA(0, 1, 0); opA(0, 1, 0); opA(0, 1, 0); opA(0, 1, 0);
        chk("drain3 count", cntA, 0);

        // 4. read+write on empty: underflow, write still lands, dout holds last pop
        opA(1, 1, 8'h77); chk("uw valid", vA, 0); chk("uw count", cntA, 1);
        chk("uw dout hold", doutA, 8'h66); chk("uw error", errA, 1);
        opA(0, 1, 0); chk("uw pop valid", vA, 1);

        // 5. reset mid-stream
        opA(1, 0, 8'hC1); opA(1, 0, 8'hC2); chk("pre-rst count", cntA, 2);
        rstA = 1'b1; @(negedge clk); rstA = 1'b0; mqA.delete();
        chk("mid rst count", cntA, 0); chk("mid rst empty", emptyA, 1);
        chk("mid rst error", errA, 0); chk("mid rst pause", pauseA, 0);
        opA(0, 1, 0); chk("post rst unf error", errA, 1); chk("post rst unf valid", vA, 0);
        uafA = 3'd0; #1; chk("af thr comb", afA, 1); uafA = 3'd3;

        // 6. wider/deeper instance: fill, random mix against model, drain
        for (int i = 0; i < 8; i++) opB(1, 0, 16'h1000 + 16'(i));
        chk("B fill count", cntB, 8); chk("B full", fullB, 1); chk("B pause", pauseB, 1);
        chk("B af", afB, 1); chk("B error", errB, 0);
        for (int i = 0; i < 20; i++) begin
            opB(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            chk("B rnd count", cntB, mqB.size());
            chk("B rnd full", fullB, mqB.size() == 8);
            chk("B rnd empty", emptyB, mqB.size() == 0);
            chk("B rnd error", errB, errB_m);
        end
        for (int i = 0; i < 8; i++) opB(0, 1, 0);
        chk("B drained", emptyB, 1);

        @(negedge clk); @(negedge clk);
        chk("A scoreboard empty", expA.size(), 0);
        chk("B scoreboard empty", expB.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_param_flow.md
Name: fifo_param_flow

Overview:
- Parametrised synchronous FIFO; next generation of the fixed 4x8 FIFO used in the PCIe switching datapath.
- Generalises width and depth and adds:
  - runtime-programmable almost-full/almost-empty thresholds;
  - an occupancy count;
  - a hysteretic pause (flow-control) output;
  - registered read data with a valid strobe.
- Sits between the arbiter/demux stages as the per-lane buffer; fifo_pause drives upstream back-pressure.

Parameters:
- DATA_SIZE, 8, width of each entry in bits.
- ADDR_SIZE, 2, log2 of depth; DEPTH = 2**ADDR_SIZE (default 4 entries).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- write  input  1  push request.
- read  input  1  pop request.
- data_in_push  input  DATA_SIZE  push data.
- umbral_af  input  ADDR_SIZE+1  almost-full threshold (count >= umbral_af).
- umbral_ae  input  ADDR_SIZE+1  almost-empty threshold (count <= umbral_ae).
- data_out_pop  output  DATA_SIZE  registered pop data.
- valid_out  output  1  data_out_pop holds newly popped data this cycle.
- fifo_count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH.
- Fifo_full  output  1  count == DEPTH.
- fifo_empty  output  1  count == 0.
- almost_full  output  1  count >= umbral_af.
- almost_empty  output  1  count <= umbral_ae.
- fifo_pause  output  1  hysteretic back-pressure request.
- fifo_error  output  1  sticky overflow/underflow indicator.

Behaviour:
- Reset:
  - wr_ptr = rd_ptr = count = 0.
  - data_out_pop = 0, valid_out = 0, fifo_pause = 0, fifo_error = 0.
  - Hence fifo_empty = 1 and Fifo_full = 0; almost_empty = 1 whenever umbral_ae >= 0, so always after reset.
  - Memory contents are not cleared.
  - Reset mid-operation discards all entries on that edge.
- Status flags: Fifo_full, fifo_empty, almost_full and almost_empty are combinational decodes of the registered count and the threshold inputs. They change the cycle after the edge that changes count. Threshold changes take effect combinationally.
- Accept rules, evaluated with the count before the edge:
  - rd_ok = read & (count != 0).
  - wr_ok = write & ((count != DEPTH) | rd_ok).
- Write when full with no accepted read: data is dropped, pointers unchanged, fifo_error set.
- Read when empty: underflow, fifo_error set, valid_out = 0, data_out_pop holds.
  - If write is also asserted, the write is still accepted (no read-through).
- Simultaneous read and write, both accepted: count unchanged, both pointers advance.
  - When full, rd_ptr == wr_ptr. data_out_pop gets the OLD entry (read-before-write); the new data replaces it.
- Pointers are ADDR_SIZE bits and wrap naturally from DEPTH-1 to 0.
- Count update: count_next = count + wr_ok - rd_ok. Width ADDR_SIZE+1, never exceeds DEPTH, never goes below 0.
- Read latency: on an edge with rd_ok, data_out_pop <= mem[rd_ptr] and valid_out <= 1. Data appears the cycle after the read request. Otherwise valid_out <= 0 and data_out_pop holds its value.
- fifo_pause is registered and computed from count_next:
  - set if count_next >= umbral_af;
  - else clear if count_next <= umbral_ae;
  - else hold.
  - Set wins if the thresholds overlap.
  - It therefore updates on the same edge as count.
- fifo_error is sticky: set on any overflow or underflow attempt, cleared only by reset.
- Thresholds outside 0..DEPTH are legal; comparisons are unsigned at ADDR_SIZE+1 bits.

Test Plan (defaults DATA_SIZE=8, ADDR_SIZE=2, umbral_af=3, umbral_ae=1):
1. Reset held 2 cycles -> all outputs 0 except fifo_empty=1 and almost_empty=1; fifo_count=0.
2. Push 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles ->
   - fifo_count goes 1,2,3,4;
   - almost_empty drops after count=2;
   - almost_full and fifo_pause rise when count=3;
   - Fifo_full=1 at count=4.
   Then pop 4 times -> data_out_pop = A1..A4, each with valid_out=1 one cycle after its read. fifo_pause stays 1 until count=1, then clears. Order and wrap are correct.
3. Full FIFO; push 0x55 without read -> fifo_error=1, count stays 4, 0x55 never popped. Then read+write 0x66 on one edge -> oldest entry out, count 4; 0x66 pops last.
4. Empty FIFO; read+write 0x77 on one edge -> fifo_error=1, valid_out=0, count=1. Next read -> 0x77 with valid_out=1.
5. Push 2 entries, assert reset mid-stream -> count=0, fifo_empty=1, fifo_error=0, fifo_pause=0. A subsequent read is an underflow.
6. Regression with ADDR_SIZE=3, DATA_SIZE=16 -> 8 pushes fill to Fifo_full, 20 mixed random ops match a reference queue model, pointer wrap is exercised.
